// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - CSR numbers, exception codes, field positions and write masks
package csr_regfile_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int CRMD_IE       = 2;
    localparam int ESTAT_IS_TI   = 11;
    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;

    localparam logic [8:0]  CRMD_RESET   = 9'h008;
    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;

    // Bit-masked merge restricted to the writable fields of the target register
    function automatic logic [31:0] masked_write(input logic [31:0] old, input logic [31:0] wmask,
                                                 input logic [31:0] wvalue, input logic [31:0] fmask);
        return (old & ~(wmask & fmask)) | (wvalue & wmask & fmask);
    endfunction

    // Address-related exceptions that record a bad virtual address
    function automatic logic badv_ecode(input logic [5:0] ecode);
        return (ecode == ECODE_ADE) || (ecode == ECODE_ALE) || (ecode == ECODE_TLBR) ||
               (ecode == ECODE_PIL) || (ecode == ECODE_PIS) || (ecode == ECODE_PIF) ||
               (ecode == ECODE_PME) || (ecode == ECODE_PPI);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - TCFG/TVAL stable timer with one-shot and periodic modes
module csr_timer
    import csr_regfile_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               timer_set
);

    // Internal enable: TCFG.En stays as written, but a one-shot expiry stops counting
    logic               running;
    logic [TIMER_W-1:0] reload;

    assign reload    = {tcfg[TIMER_W-1:2], 2'b00};
    assign timer_set = running && (tval == '0);

    // Load on TCFG write, otherwise count down, reload or park at all-ones on expiry
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tcfg    <= '0;
            tval    <= '0;
            running <= 1'b0;
        end else if (tcfg_we) begin
            tcfg    <= tcfg_wdata;
            running <= tcfg_wdata[TCFG_EN];
            if (tcfg_wdata[TCFG_EN]) begin
                tval <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
            end
        end else if (timer_set) begin
            if (tcfg[TCFG_PERIODIC]) begin
                tval <= reload;
            end else begin
                tval    <= '1;
                running <= 1'b0;
            end
        end else if (running) begin
            tval <= tval - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - architectural CSR file with exception/ERTN side effects and interrupts
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int TIMER_W   = 32,
    parameter int CSR_NUM_W = 14
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 csr_re,
    input  logic [CSR_NUM_W-1:0] csr_num,
    output logic [31:0]          csr_rvalue,
    input  logic                 csr_we,
    input  logic [31:0]          csr_wmask,
    input  logic [31:0]          csr_wvalue,
    input  logic                 wb_ex,
    input  logic                 ertn_flush,
    input  logic [31:0]          wb_pc,
    input  logic [5:0]           wb_ecode,
    input  logic [8:0]           wb_esubcode,
    input  logic [31:0]          wb_vaddr,
    input  logic                 current_exc_fetch,
    input  logic [7:0]           hw_int_in,
    input  logic                 ipi_int_in,
    input  logic [31:0]          coreid_in,
    output logic                 has_int,
    output logic [31:0]          ex_entry,
    output logic [31:0]          ertn_entry
);

    logic [8:0]         crmd;
    logic [2:0]         prmd;
    logic [12:0]        ecfg_lie;
    logic [12:0]        estat_is;
    logic [5:0]         estat_ecode;
    logic [8:0]         estat_esubcode;
    logic [31:0]        era;
    logic [31:0]        badv;
    logic [25:0]        eentry;
    logic [31:0]        save [4];
    logic [31:0]        tid;
    logic [TIMER_W-1:0] tcfg;
    logic [TIMER_W-1:0] tval;
    logic               timer_set;

    logic               wr_en;
    logic               ticlr_clr;
    logic [31:0]        field_mask;
    logic [31:0]        wr_data;
    logic               unused_inputs;

    // The read path is always live, so the read qualifier carries no information here
    assign unused_inputs = csr_re;

    // Exception and ERTN commits take the writeback slot; a coincident CSR write is dropped
    assign wr_en     = csr_we & ~wb_ex & ~ertn_flush;
    assign ticlr_clr = wr_en && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];
    assign wr_data   = masked_write(csr_rvalue, csr_wmask, csr_wvalue, field_mask);

    assign has_int    = crmd[CRMD_IE] & (|(estat_is & ecfg_lie));
    assign ex_entry   = {eentry, 6'b0};
    assign ertn_entry = era;

    csr_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .tcfg_we    (wr_en && (csr_num == CSR_TCFG)),
        .tcfg_wdata (wr_data[TIMER_W-1:0]),
        .tcfg       (tcfg),
        .tval       (tval),
        .timer_set  (timer_set)
    );

    // Combinational read mux; unmapped addresses and TICLR read as zero
    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            CSR_CRMD:   csr_rvalue = {23'b0, crmd};
            CSR_PRMD:   csr_rvalue = {29'b0, prmd};
            CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
            CSR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
            CSR_ERA:    csr_rvalue = era;
            CSR_BADV:   csr_rvalue = badv;
            CSR_EENTRY: csr_rvalue = {eentry, 6'b0};
            CSR_SAVE0:  csr_rvalue = save[0];
            CSR_SAVE1:  csr_rvalue = save[1];
            CSR_SAVE2:  csr_rvalue = save[2];
            CSR_SAVE3:  csr_rvalue = save[3];
            CSR_TID:    csr_rvalue = tid;
            CSR_TCFG:   csr_rvalue = 32'(tcfg);
            CSR_TVAL:   csr_rvalue = 32'(tval);
            default:    csr_rvalue = 32'h0;
        endcase
    end

    // Writable-field mask of the addressed register; read-only fields keep their value
    always_comb begin
        field_mask = 32'h0;
        case (csr_num)
            CSR_CRMD:   field_mask = CRMD_WMASK;
            CSR_PRMD:   field_mask = PRMD_WMASK;
            CSR_ECFG:   field_mask = ECFG_WMASK;
            CSR_ESTAT:  field_mask = ESTAT_WMASK;
            CSR_ERA:    field_mask = 32'hFFFF_FFFF;
            CSR_EENTRY: field_mask = EENTRY_WMASK;
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3,
            CSR_TID, CSR_TCFG:
                        field_mask = 32'hFFFF_FFFF;
            default:    field_mask = 32'h0;
        endcase
    end

    // Register state: interrupt sampling every cycle, then exception > ERTN > CSR write
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd           <= CRMD_RESET;
            prmd           <= '0;
            ecfg_lie       <= '0;
            estat_is       <= '0;
            estat_ecode    <= '0;
            estat_esubcode <= '0;
            era            <= '0;
            badv           <= '0;
            eentry         <= '0;
            for (int i = 0; i < 4; i++) begin
                save[i] <= '0;
            end
            tid            <= coreid_in;
        end else begin
            estat_is[9:2] <= hw_int_in;
            estat_is[12]  <= ipi_int_in;
            if (timer_set) begin
                estat_is[ESTAT_IS_TI] <= 1'b1;
            end else if (ticlr_clr) begin
                estat_is[ESTAT_IS_TI] <= 1'b0;
            end

            if (wb_ex) begin
                prmd           <= crmd[2:0];
                crmd[2:0]      <= 3'b000;
                era            <= wb_pc;
                estat_ecode    <= wb_ecode;
                estat_esubcode <= wb_esubcode;
                if (badv_ecode(wb_ecode)) begin
                    badv <= current_exc_fetch ? wb_pc : wb_vaddr;
                end
            end else if (ertn_flush) begin
                crmd[2:0] <= prmd;
            end else if (csr_we) begin
                case (csr_num)
                    CSR_CRMD:   crmd          <= wr_data[8:0];
                    CSR_PRMD:   prmd          <= wr_data[2:0];
                    CSR_ECFG:   ecfg_lie      <= wr_data[12:0];
                    CSR_ESTAT:  estat_is[1:0] <= wr_data[1:0];
                    CSR_ERA:    era           <= wr_data;
                    CSR_EENTRY: eentry        <= wr_data[31:6];
                    CSR_SAVE0:  save[0]       <= wr_data;
                    CSR_SAVE1:  save[1]       <= wr_data;
                    CSR_SAVE2:  save[2]       <= wr_data;
                    CSR_SAVE3:  save[3]       <= wr_data;
                    CSR_TID:    tid           <= wr_data;
                    default:    ;
                endcase
            end
        end
    end

endmodule
